tiny_nn_seq: RTL and testbench
==============================

Name: tiny_nn_seq

Overview:
- Parametrised command sequencer for the tiny-nn convolve core. It generalises the fixed 4x2 controller to a WxH value array.
- Decodes 16-bit commands on data_i, loads W*H parameters, then streams values while driving the core's shift, multiply and accumulate controls.
- Serialises each 16-bit fp result onto the 8-bit data_o.
- Adds parameter reuse (convolve without reload) and optional ReLU on results.
- Sits at top level between the chip pins and tiny_nn_core; the core is instantiated beside it, not inside it.

Parameters:
- CountWidth, 12, width of the result-count field; must be <= 12.
- ValArrayWidth, 4, core value-array columns (W), >= 1.
- ValArrayHeight, 2, core value-array rows (H) = exec phases per result, >= 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- data_i  in  16  command word, parameter or value stream
- data_o  out  8  result byte stream; 0xFF when no result is being presented
- busy_o  out  1  high whenever state != Idle
- val_shift_o  out  H  one-hot row shift enable to core
- param_write_o  out  W*H  one-hot parameter write enable to core
- mul_row_sel_o  out  max(1,$clog2(H))  row select to core (equals current phase)
- mul_en_o  out  1  multiply enable to core
- accumulate_en_o  out  2  [0] accumulate every exec cycle; [1] accumulate on the last phase
- accumulate_i  in  16  core accumulator result (fp_t)

Behaviour:
- Reset: state=Idle, phase=0, counter=0, param_write=0, params_valid=0, relu_q=0. All control outputs are 0, busy_o=0, data_o=0xFF. All control flops are asynchronously reset.
- Command decode happens in Idle only: opcode=data_i[15:12], count N=data_i[CountWidth-1:0]. Words received in any other state are treated as data, never as commands.
- Opcodes:
  - CmdOpConvolve: load, then exec, relu off.
  - CmdOpConvolveRelu: load, then exec, relu on.
  - CmdOpConvolveReuse: exec only, relu off.
  - CmdOpConvolveReuseRelu: exec only, relu on.
  - Any other opcode: stay Idle.
- Reuse opcodes with params_valid=0 are ignored and the block stays Idle.
- Idle → ParamIn:
  - Applies in the cycle after a load opcode.
  - param_write_o=1<<k during ParamIn cycle k, k=0..W*H-1; data_i in that cycle is parameter k.
  - After cycle W*H-1, go to Exec and set params_valid=1.
  - ParamIn takes exactly W*H cycles.
- Idle → Exec: applies in the cycle after a reuse opcode (no ParamIn).
- Exec:
  - phase counts 0..H-1 and wraps to 0.
  - val_shift_o=1<<phase, mul_row_sel_o=phase, mul_en_o=1, accumulate_en_o[0]=1, accumulate_en_o[1]=(phase==H-1).
  - At phase==H-1: if counter!=0, decrement counter; else go to Idle.
  - Exec lasts exactly (N+1)*H cycles and produces N+1 results.
  - N=0 yields one result. N=2^CountWidth-1 must not wrap.
- data_o in Exec:
  - phase 0 presents r[7:0]; phase 1 presents r[15:8]; phases >= 2 present 0xFF.
  - r=accumulate_i, or 16'h0000 if relu_q=1 and accumulate_i[15]=1 (negative fp16, including -0).
- data_o outside Exec is 0xFF.
- params_valid stays set across commands and is cleared only by reset.
- relu_q is latched at command accept and held through the whole command.
- Reset asserted mid-ParamIn or mid-Exec: immediate return to Idle, all outputs at reset values, params_valid=0.
- The first Idle cycle after Exec accepts a new command; back-to-back commands have no dead cycle.

Decomposition:
- tiny_nn_pkg holds:
  - cmd_op_e with CmdOpConvolve=1, CmdOpConvolveReuse=2, CmdOpConvolveRelu=3, CmdOpConvolveReuseRelu=4.
  - The existing fp_t.
  - Function fp_relu(fp_t) returning fp_t.
- Sub-module tiny_nn_out_ser: phase plus result in, data_o out, with ReLU applied. It is purely combinational and kept separate for reuse by future ops.
- State enum states: Idle, ParamIn, Exec. It stays local to the module.

Test Plan:
- Default params (W=4, H=2). Drive 0x1002, then params 0x0001..0x0008, then 6 value words.
  - Expect param_write_o = 0x01, 0x02 … 0x80 on consecutive cycles.
  - Then 6 Exec cycles; val_shift_o alternates 01/10; accumulate_en_o alternates 01/11.
  - Expect busy_o low on cycle 15 after the command.
- Same load, then immediately 0x2000 on the first Idle cycle.
  - Expect no ParamIn and exactly 2 Exec cycles.
  - Expect data_o=accumulate_i[7:0], then accumulate_i[15:8].
- 0x4000 right after reset → busy_o stays 0. After one full 0x1000 command, 0x4000 → 2-cycle Exec with ReLU.
  - accumulate_i=0xBC00 → data_o 0x00, 0x00.
  - accumulate_i=0x3C00 → data_o 0x00, 0x3C.
- Invalid opcode 0xF123 in Idle → no state change, data_o=0xFF.
- 0x1001 sent during Exec → treated as a value word and ignored as a command.
- W=3, H=3:
  - 0x1001 → 9 ParamIn cycles, then 6 Exec cycles.
  - mul_row_sel_o = 0,1,2,0,1,2; data_o byte on phase 2 = 0xFF.
- Assert rst_ni low at ParamIn cycle 3 → all outputs reset on the same cycle. A subsequent 0x2000 is ignored.

Source files
------------

// File: rtl/tiny_nn_pkg.sv
// Shared types for the tiny-nn convolve block: command opcodes,
// the fp16 result type and the ReLU helper.
package tiny_nn_pkg;

  typedef enum logic [3:0] {
    CmdOpConvolve          = 4'd1,
    CmdOpConvolveReuse     = 4'd2,
    CmdOpConvolveRelu      = 4'd3,
    CmdOpConvolveReuseRelu = 4'd4
  } cmd_op_e;

  typedef struct packed {
    logic       sign;
    logic [4:0] exponent;
    logic [9:0] mantissa;
  } fp_t;

  localparam fp_t        FpZero   = '0;
  localparam logic [7:0] DataIdle = 8'hFF;

  // Any value with the sign bit set, -0 included, clamps to +0.
  function automatic fp_t fp_relu(input fp_t x);
    return x.sign ? FpZero : x;
  endfunction

endpackage

// File: rtl/tiny_nn_out_ser.sv
// Result serialiser: low byte on phase 0, high byte on phase 1, 0xFF otherwise.
// Ports: active, phase, relu, result in; data out. Purely combinational.
module tiny_nn_out_ser
  import tiny_nn_pkg::*;
#(
  parameter int unsigned PhaseWidth = 1
) (
  input  logic                  active,
  input  logic [PhaseWidth-1:0] phase,
  input  logic                  relu,
  input  fp_t                   result,
  output logic [7:0]            data
);

  fp_t res;

  always_comb begin
    res  = relu ? fp_relu(result) : result;
    data = DataIdle;
    if (active) begin
      if (phase == '0) begin
        data = res[7:0];
      end else if (phase == PhaseWidth'(1)) begin
        data = res[15:8];
      end
    end
  end

endmodule

// File: rtl/tiny_nn_seq.sv
// Command sequencer for the tiny-nn core: decodes commands, loads params,
// drives exec controls and serialises results. Ports: clk_i, rst_ni,
// data_i/data_o, busy_o, core controls out, accumulate_i in.
module tiny_nn_seq
  import tiny_nn_pkg::*;
#(
  parameter int unsigned CountWidth     = 12,
  parameter int unsigned ValArrayWidth  = 4,
  parameter int unsigned ValArrayHeight = 2,
  localparam int unsigned NumParams =
    ValArrayWidth * ValArrayHeight,
  localparam int unsigned RowSelWidth =
    (ValArrayHeight > 1) ? $clog2(ValArrayHeight) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [15:0]               data_i,
  output logic [7:0]                data_o,
  output logic                      busy_o,
  output logic [ValArrayHeight-1:0] val_shift_o,
  output logic [NumParams-1:0]      param_write_o,
  output logic [RowSelWidth-1:0]    mul_row_sel_o,
  output logic                      mul_en_o,
  output logic [1:0]                accumulate_en_o,
  input  fp_t                       accumulate_i
);

  typedef enum logic [1:0] {
    Idle,
    ParamIn,
    Exec
  } state_e;

  localparam logic [RowSelWidth-1:0] LastPhase =
    RowSelWidth'(ValArrayHeight - 1);

  state_e                      state_q, state_d;
  logic [RowSelWidth-1:0]      phase_q, phase_d;
  logic [CountWidth-1:0]       count_q, count_d;
  logic [NumParams-1:0]        pw_q, pw_d;
  logic                        pv_q, pv_d;
  logic                        relu_q, relu_d;
  logic [ValArrayHeight-1:0]   shift_q;
  logic [RowSelWidth-1:0]      row_q;
  logic                        mul_q;
  logic [1:0]                  acc_q;

  logic [3:0] opcode;
  logic       is_load;
  logic       is_reuse;
  logic       cmd_relu;
  logic       exec_d;

  assign opcode = data_i[15:12];

  // Reuse only makes sense once a parameter set has been loaded.
  always_comb begin
    is_load  = 1'b0;
    is_reuse = 1'b0;
    cmd_relu = 1'b0;
    unique case (1'b1)
      opcode == CmdOpConvolve: begin
        is_load = 1'b1;
      end
      opcode == CmdOpConvolveRelu: begin
        is_load  = 1'b1;
        cmd_relu = 1'b1;
      end
      opcode == CmdOpConvolveReuse: begin
        is_reuse = pv_q;
      end
      opcode == CmdOpConvolveReuseRelu: begin
        is_reuse = pv_q;
        cmd_relu = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    count_d = count_q;
    pw_d    = '0;
    pv_d    = pv_q;
    relu_d  = relu_q;
    unique case (state_q)
      Idle: begin
        phase_d = '0;
        if (is_load) begin
          state_d = ParamIn;
          pw_d    = NumParams'(1);
          count_d = data_i[CountWidth-1:0];
          relu_d  = cmd_relu;
        end else if (is_reuse) begin
          state_d = Exec;
          count_d = data_i[CountWidth-1:0];
          relu_d  = cmd_relu;
        end
      end
      ParamIn: begin
        if (pw_q[NumParams-1]) begin
          state_d = Exec;
          pv_d    = 1'b1;
        end else begin
          pw_d = pw_q << 1;
        end
      end
      Exec: begin
        if (phase_q == LastPhase) begin
          phase_d = '0;
          if (count_q != '0) begin
            count_d = count_q - CountWidth'(1);
          end else begin
            state_d = Idle;
          end
        end else begin
          phase_d = phase_q + RowSelWidth'(1);
        end
      end
      default: state_d = Idle;
    endcase
  end

  assign exec_d = (state_d == Exec);

  // Core controls are registered from the next phase so they line
  // up with state_q/phase_q without a decode stage on the outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      phase_q <= '0;
      count_q <= '0;
      pw_q    <= '0;
      pv_q    <= 1'b0;
      relu_q  <= 1'b0;
      shift_q <= '0;
      row_q   <= '0;
      mul_q   <= 1'b0;
      acc_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      count_q <= count_d;
      pw_q    <= pw_d;
      pv_q    <= pv_d;
      relu_q  <= relu_d;
      mul_q   <= exec_d;
      shift_q <= exec_d
        ? ValArrayHeight'(1) << phase_d
        : '0;
      row_q   <= exec_d ? phase_d : '0;
      acc_q   <= exec_d
        ? {phase_d == LastPhase, 1'b1}
        : 2'b00;
    end
  end

  assign busy_o          = (state_q != Idle);
  assign param_write_o   = pw_q;
  assign val_shift_o     = shift_q;
  assign mul_row_sel_o   = row_q;
  assign mul_en_o        = mul_q;
  assign accumulate_en_o = acc_q;

  tiny_nn_out_ser #(
    .PhaseWidth(RowSelWidth)
  ) u_out_ser (
    .active(state_q == Exec),
    .phase (phase_q),
    .relu  (relu_q),
    .result(accumulate_i),
    .data  (data_o)
  );

endmodule

// File: tb/tb_tiny_nn_seq.sv
// Bench for tiny_nn_seq: a 4x2 and a 3x3 instance against a
// command-expansion model, plus directed literal checks.
module tb_tiny_nn_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] d0, d1, a0, a1;

  logic [7:0] do0, pw0;
  logic       busy0, mul0;
  logic [1:0] vs0, ae0;
  logic [0:0] rs0;

  logic [7:0] do1;
  logic [8:0] pw1;
  logic       busy1, mul1;
  logic [2:0] vs1;
  logic [1:0] rs1, ae1;

  int total = 0;
  int bad   = 0;

  int pos [2];
  int tot [2];
  int plen[2];
  bit pv  [2];
  bit relu[2];

  always #5 clk = ~clk;

  tiny_nn_seq u0 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(d0),
    .data_o(do0), .busy_o(busy0), .val_shift_o(vs0),
    .param_write_o(pw0), .mul_row_sel_o(rs0),
    .mul_en_o(mul0), .accumulate_en_o(ae0),
    .accumulate_i(a0)
  );

  tiny_nn_seq #(
    .CountWidth(12), .ValArrayWidth(3), .ValArrayHeight(3)
  ) u1 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(d1),
    .data_o(do1), .busy_o(busy1), .val_shift_o(vs1),
    .param_write_o(pw1), .mul_row_sel_o(rs1),
    .mul_en_o(mul1), .accumulate_en_o(ae1),
    .accumulate_i(a1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // A command expands into a script: W*H param cycles (load only)
  // followed by (N+1)*H exec cycles; pos walks through that script.
  task automatic model_step(
    input int i, input int W, input int H,
    input logic [15:0] d, input logic [15:0] acc,
    input int pw, input int vs, input int rs, input int mul,
    input int ae, input int busy, input int dout
  );
    int e_pw, e_vs, e_rs, e_mul, e_ae, e_busy, e_do, ph, op, n;
    logic [15:0] r;
    e_pw = 0; e_vs = 0; e_rs = 0; e_mul = 0;
    e_ae = 0; e_busy = 0; e_do = 255;
    if (!rst_n) begin
      pos[i] = 0; tot[i] = 0; plen[i] = 0;
      pv[i] = 0; relu[i] = 0;
    end
    if (pos[i] < tot[i]) begin
      e_busy = 1;
      if (pos[i] < plen[i]) begin
        e_pw = 1 << pos[i];
      end else begin
        ph = (pos[i] - plen[i]) % H;
        e_vs = 1 << ph;
        e_rs = ph;
        e_mul = 1;
        e_ae = (ph == H - 1) ? 3 : 1;
        r = (relu[i] && acc[15]) ? 16'h0000 : acc;
        if (ph == 0) e_do = int'(r[7:0]);
        else if (ph == 1) e_do = int'(r[15:8]);
      end
    end
    chk($sformatf("u%0d.busy", i), busy, e_busy);
    chk($sformatf("u%0d.param_write", i), pw, e_pw);
    chk($sformatf("u%0d.val_shift", i), vs, e_vs);
    chk($sformatf("u%0d.row_sel", i), rs, e_rs);
    chk($sformatf("u%0d.mul_en", i), mul, e_mul);
    chk($sformatf("u%0d.acc_en", i), ae, e_ae);
    chk($sformatf("u%0d.data_o", i), dout, e_do);
    if (rst_n) begin
      if (pos[i] < tot[i]) begin
        if (pos[i] == plen[i] - 1) pv[i] = 1;
        pos[i]++;
      end else begin
        op = int'(d[15:12]);
        n  = int'(d[11:0]);
        if (op == 1 || op == 3) begin
          plen[i] = W * H;
          tot[i]  = plen[i] + (n + 1) * H;
          pos[i]  = 0;
          relu[i] = (op == 3);
        end else if ((op == 2 || op == 4) && pv[i]) begin
          plen[i] = 0;
          tot[i]  = (n + 1) * H;
          pos[i]  = 0;
          relu[i] = (op == 4);
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step(0, 4, 2, d0, a0, int'(pw0), int'(vs0),
        int'(rs0), int'(mul0), int'(ae0), int'(busy0), int'(do0));
      model_step(1, 3, 3, d1, a1, int'(pw1), int'(vs1),
        int'(rs1), int'(mul1), int'(ae1), int'(busy1), int'(do1));
    end
  end

  task automatic step(
    input logic [15:0] x0, input logic [15:0] y0,
    input logic [15:0] x1, input logic [15:0] y1
  );
    @(posedge clk);
    #1;
    d0 = x0; a0 = y0; d1 = x1; a1 = y1;
    @(negedge clk);
  endtask

  task automatic s0(input logic [15:0] x, input logic [15:0] y);
    step(x, y, 16'h0000, 16'h0000);
  endtask

  task automatic s1(input logic [15:0] x, input logic [15:0] y);
    step(16'h0000, 16'h0000, x, y);
  endtask

  function automatic logic [15:0] rnd_word();
    logic [15:0] w;
    int op;
    w = 16'($urandom);
    if ($urandom_range(0, 5) == 0) begin
      w[15:12] = 4'($urandom_range(1, 4));
      w[11:0]  = 12'($urandom_range(0, 3));
    end else begin
      op = int'($urandom_range(0, 11));
      w[15:12] = (op == 0) ? 4'd0 : 4'(op + 4);
    end
    return w;
  endfunction

  initial begin
    rst_n = 1'b0;
    d0 = '0; d1 = '0; a0 = '0; a1 = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", int'(busy0), 0);
    chk("rst.data_o", int'(do0), 8'hFF);
    chk("rst.param_write", int'(pw0), 0);
    chk("rst.mul_en", int'(mul0), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    s0(16'h4000, 0);
    s0(0, 0);
    chk("reuse_noparam.busy", int'(busy0), 0);

    s0(16'h1002, 0);
    for (int k = 0; k < 8; k++) begin
      s0(16'(k + 1), 0);
      chk("load.param_write", int'(pw0), 1 << k);
    end
    for (int j = 0; j < 6; j++) begin
      s0(16'h0100 + 16'(j), 16'h4321);
      chk("exec.val_shift", int'(vs0), (j % 2) ? 2 : 1);
      chk("exec.acc_en", int'(ae0), (j % 2) ? 3 : 1);
    end
    s0(16'h2000, 0);
    chk("cycle15.busy", int'(busy0), 0);
    s0(0, 16'h1234);
    chk("reuse.lo", int'(do0), 8'h34);
    s0(0, 16'h1234);
    chk("reuse.hi", int'(do0), 8'h12);
    s0(0, 0);
    chk("reuse.done", int'(busy0), 0);

    s0(16'h1000, 0);
    repeat (10) s0(16'h00AA, 0);
    s0(16'h4000, 0);
    s0(0, 16'hBC00);
    chk("relu_neg.lo", int'(do0), 8'h00);
    s0(0, 16'hBC00);
    chk("relu_neg.hi", int'(do0), 8'h00);
    s0(16'h4000, 0);
    s0(0, 16'h3C00);
    chk("relu_pos.lo", int'(do0), 8'h00);
    s0(0, 16'h3C00);
    chk("relu_pos.hi", int'(do0), 8'h3C);

    s0(16'hF123, 0);
    s0(0, 0);
    chk("badop.busy", int'(busy0), 0);
    chk("badop.data_o", int'(do0), 8'hFF);

    s0(16'h2001, 0);
    s0(16'h1001, 0);
    s0(16'h1001, 0);
    chk("cmd_in_exec.pw", int'(pw0), 0);
    s0(0, 0);
    s0(0, 0);
    s0(0, 0);
    chk("cmd_in_exec.busy", int'(busy0), 0);

    s1(16'h1001, 0);
    for (int k = 0; k < 9; k++) begin
      s1(16'h0010 + 16'(k), 0);
      chk("w3.param_write", int'(pw1), 1 << k);
    end
    for (int j = 0; j < 6; j++) begin
      s1(0, 16'hA55A);
      chk("w3.row_sel", int'(rs1), j % 3);
      if (j % 3 == 2) chk("w3.ph2_data", int'(do1), 8'hFF);
      if (j % 3 == 0) chk("w3.ph0_data", int'(do1), 8'h5A);
    end
    s1(0, 0);
    chk("w3.done", int'(busy1), 0);

    s0(16'h1000, 0);
    s0(1, 0);
    s0(2, 0);
    s0(3, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.pw", int'(pw0), 0);
    chk("midrst.busy", int'(busy0), 0);
    chk("midrst.data_o", int'(do0), 8'hFF);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    s0(16'h2000, 0);
    s0(0, 0);
    chk("midrst.reuse_ignored", int'(busy0), 0);

    for (int c = 0; c < 3000; c++) begin
      step(rnd_word(), 16'($urandom), rnd_word(), 16'($urandom));
    end

    for (int g = 0; g < 200 && busy0; g++) s0(0, 0);
    chk("drain.busy", int'(busy0), 0);
    s0(16'h1000, 0);
    repeat (10) s0(0, 0);
    s0(16'h2FFF, 0);
    for (int g = 0; g < 8192; g++) begin
      s0(0, 16'($urandom));
      if (g == 8191) chk("maxn.last_busy", int'(busy0), 1);
    end
    s0(0, 0);
    chk("maxn.done", int'(busy0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
